// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: EX-stage operand mux
// selects, multicycle FSM states and the shadow-slot records.
package hazard_fwd_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  // ALU operand select: register file, WB write data, EX/MEM result.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     reg_write;
    logic     mem_read;
  } slot_t;

  typedef struct packed {
    slot_t    base;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     multicycle;
  } ex_slot_t;

  // True when the slot will write a non-x0 register that matches rs.
  function automatic logic slot_writes(slot_t s, reg_idx_t rs);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// ID-stage request and hazard/forwarding control bundle.
interface hazard_fwd_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       id_multicycle;
  logic       ex_branch_taken;
  logic       md_done;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       pc_write;
  logic       ifid_write;
  logic       idex_bubble;
  logic       flush_ifid;
  logic       md_start;
  logic       stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_multicycle, ex_branch_taken, md_done,
    input  ForwardA, ForwardB, pc_write, ifid_write, idex_bubble, flush_ifid,
           md_start, stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_reg_write, id_mem_read, id_multicycle, ex_branch_taken, md_done,
    output ForwardA, ForwardB, pc_write, ifid_write, idex_bubble, flush_ifid,
           md_start, stall
  );
endinterface

// File: rtl/hazard_fwd_ctrl_fwd_select.sv
// One ALU operand forwarding select; the nearer (MEM) producer wins over WB.
module fwd_select
  import hazard_fwd_ctrl_pkg::*;
(
  input  reg_idx_t i_rs,
  input  slot_t    i_mem,
  input  slot_t    i_wb,
  output fwd_sel_e o_sel
);

  logic w_unused_mem_read;
  assign w_unused_mem_read = &{1'b0, i_mem.mem_read, i_wb.mem_read};

  always_comb begin
    o_sel = FWD_RF;
    if (slot_writes(i_mem, i_rs))
      o_sel = FWD_MEM;
    else if (slot_writes(i_wb, i_rs))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Pipeline hazard unit: shadow EX/MEM/WB slots, forwarding selects, load-use
// stall, branch flush and the multicycle (mul/div) hold FSM.
module hazard_fwd_ctrl
  import hazard_fwd_ctrl_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  hazard_fwd_ctrl_if.slave  bus
);

  md_state_e r_state, w_state_nxt;
  ex_slot_t  r_ex, w_ex_in;
  slot_t     r_mem, r_wb;

  logic     w_load_use, w_md_launch, w_advance;
  logic     w_pc_write, w_ifid_write, w_bubble, w_flush, w_md_start;
  fwd_sel_e w_fwd_a, w_fwd_b;

  fwd_select u_fwd_a (.i_rs(r_ex.rs1), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd_a));
  fwd_select u_fwd_b (.i_rs(r_ex.rs2), .i_mem(r_mem), .i_wb(r_wb), .o_sel(w_fwd_b));

  assign w_load_use = bus.id_valid && r_ex.base.valid && r_ex.base.mem_read &&
                      (r_ex.base.rd != '0) &&
                      ((bus.id_use_rs1 && (bus.id_rs1 == r_ex.base.rd)) ||
                       (bus.id_use_rs2 && (bus.id_rs2 == r_ex.base.rd)));

  assign w_md_launch = r_ex.base.valid && r_ex.multicycle;

  // The launch cycle already holds the pipeline so the mul/div stays in EX
  // for the whole BUSY period; it leaves EX on the md_done cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    w_md_start   = 1'b0;
    w_advance    = 1'b1;
    if (rst_n) begin
      unique case (r_state)
        MD_IDLE: begin
          if (w_md_launch) begin
            w_md_start   = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_advance    = 1'b0;
            w_state_nxt  = MD_BUSY;
          end else if (bus.ex_branch_taken) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
          end else if (w_load_use) begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_bubble     = 1'b1;
          end
        end
        MD_BUSY: begin
          if (bus.md_done) begin
            w_state_nxt = MD_IDLE;
          end else begin
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_advance    = 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_ex_in = '0;
    if (bus.id_valid && !w_bubble) begin
      w_ex_in.base.valid     = 1'b1;
      w_ex_in.base.rd        = bus.id_rd;
      w_ex_in.base.reg_write = bus.id_reg_write;
      w_ex_in.base.mem_read  = bus.id_mem_read;
      w_ex_in.rs1            = bus.id_rs1;
      w_ex_in.rs2            = bus.id_rs2;
      w_ex_in.multicycle     = bus.id_multicycle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_ex    <= '0;
      r_mem   <= '0;
      r_wb    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_advance) begin
        r_wb  <= r_mem;
        r_mem <= r_ex.base;
        r_ex  <= w_ex_in;
      end
    end
  end

  assign bus.ForwardA    = w_fwd_a;
  assign bus.ForwardB    = w_fwd_b;
  assign bus.pc_write    = w_pc_write;
  assign bus.ifid_write  = w_ifid_write;
  assign bus.idex_bubble = w_bubble;
  assign bus.flush_ifid  = w_flush;
  assign bus.md_start    = w_md_start;
  assign bus.stall       = ~w_pc_write;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: the driver queues the expected control
// vector for each cycle, a monitor pops it at the falling edge and compares.
module tb_hazard_fwd_ctrl;

  logic clk;
  logic rst_n;

  hazard_fwd_ctrl_if bus ();

  hazard_fwd_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pcw;
    logic       ifw;
    logic       bub;
    logic       fl;
    logic       ms;
    logic       st;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic rw, input logic mr, input logic mc);
    bus.id_valid      = v;
    bus.id_rs1        = rs1;
    bus.id_rs2        = rs2;
    bus.id_rd         = rd;
    bus.id_use_rs1    = u1;
    bus.id_use_rs2    = u2;
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.id_multicycle = mc;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1'b1, rs1, rs2, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
    set_id(1'b1, rs1, 5'd0, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic mul(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(1'b1, rs1, rs2, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  // Queue the expected outputs for the current cycle, then move to the next.
  task automatic chk(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                     input logic pcw, input logic bub, input logic fl, input logic ms);
    exp_t e;
    e.nm  = nm;
    e.fa  = fa;
    e.fb  = fb;
    e.pcw = pcw;
    e.ifw = pcw;
    e.bub = bub;
    e.fl  = fl;
    e.ms  = ms;
    e.st  = ~pcw;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic dflt(input string nm);
    chk(nm, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] got, want;
      e    = q.pop_front();
      got  = {bus.ForwardA, bus.ForwardB, bus.pc_write, bus.ifid_write,
              bus.idex_bubble, bus.flush_ifid, bus.md_start, bus.stall};
      want = {e.fa, e.fb, e.pcw, e.ifw, e.bub, e.fl, e.ms, e.st};
      n_assert++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b ms=%b st=%b, exp fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b ms=%b st=%b",
                 e.nm, got[11:10], got[9:8], got[7], got[6], got[5], got[4], got[3], got[2],
                 e.fa, e.fb, e.pcw, e.ifw, e.bub, e.fl, e.ms, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.ex_branch_taken = 1'b1;
    bus.md_done = 1'b1;
    nop();
    @(posedge clk);
    #1;
    dflt("rst0");
    dflt("rst1");
    rst_n = 1'b1;
    bus.ex_branch_taken = 1'b0;
    bus.md_done = 1'b0;

    // MEM then WB forwarding of x5
    add(5'd5, 5'd1, 5'd2);  dflt("a_add5");
    add(5'd6, 5'd5, 5'd3);  dflt("a_add6");
    add(5'd9, 5'd5, 5'd5);  chk("a_mem_fwd", 2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    nop();                  chk("a_wb_fwd", 2'd1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    // MEM producer has priority over an older WB producer of the same register
    add(5'd10, 5'd1, 5'd2);  dflt("b_i0");
    add(5'd10, 5'd3, 5'd4);  dflt("b_i1");
    add(5'd11, 5'd10, 5'd10); dflt("b_i2");
    nop();                   chk("b_mem_over_wb", 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // x0 is never forwarded and a load to x0 never stalls
    lw(5'd0, 5'd1);         dflt("c_lw_x0");
    add(5'd12, 5'd0, 5'd0); dflt("c_x0_nostall");
    nop();                  dflt("c_x0_mem");
    nop();                  dflt("c_x0_wb");

    // load-use: one stall cycle, then WB forward when the consumer reaches EX
    lw(5'd7, 5'd2);         dflt("d_lw7");
    add(5'd8, 5'd7, 5'd1);  chk("d_lu_stall", 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
                            dflt("d_lu_release");
    nop();                  chk("d_fwd_wb", 2'd1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // invalid ID or unused operand never triggers load-use
    lw(5'd7, 5'd2);         dflt("e_lw7a");
    set_id(1'b0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                            dflt("e_novalid");
    lw(5'd7, 5'd2);         dflt("e_lw7b");
    set_id(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
                            dflt("e_nouse");
    nop();                  chk("e_fwd_b_mem", 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    // taken branch overrides load-use
    lw(5'd7, 5'd2);         dflt("f_lw7");
    add(5'd8, 5'd7, 5'd1);
    bus.ex_branch_taken = 1'b1;
                            chk("f_br_over_lu", 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    bus.ex_branch_taken = 1'b0;
    nop();                  dflt("f_after_br");

    // multicycle op: start pulse, 4 held cycles, advance on md_done
    add(5'd1, 5'd3, 5'd4);  dflt("g_add1");
    mul(5'd13, 5'd1, 5'd2); dflt("g_mul_id");
    add(5'd14, 5'd13, 5'd0);
    bus.ex_branch_taken = 1'b1;
    chk("g_md_start", 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("g_busy_br",  2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ex_branch_taken = 1'b0;
    chk("g_busy2",    2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("g_busy3",    2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.md_done = 1'b1;
    chk("g_done",     2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.md_done = 1'b0;
    nop();
    chk("g_fwd_mul",  2'd2, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.md_done = 1'b1;
    dflt("g_done_idle");
    bus.md_done = 1'b0;

    // reset while BUSY abandons the operation
    mul(5'd15, 5'd0, 5'd0); dflt("h_mul_id");
    nop();                  chk("h_md_start", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
                            chk("h_busy",     2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    bus.ex_branch_taken = 1'b1;
    dflt("h_rst_busy");
    dflt("h_rst_hold");
    rst_n = 1'b1;
    bus.ex_branch_taken = 1'b0;
    dflt("h_post_rst");
    dflt("h_post_rst2");

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
